// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to APB4 master bridge, one transfer in flight, with access timeout.
module apb_master_bridge #(
    parameter int ADDR_SIZE      = 32,
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_SIZE-1:0]   cmd_addr,
    input  logic [DATA_SIZE-1:0]   cmd_wdata,
    input  logic [DATA_SIZE/8-1:0] cmd_strb,
    input  logic                   cmd_prot,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_SIZE-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic [ADDR_SIZE-1:0]   PADDR,
    output logic                   PPROT,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [DATA_SIZE-1:0]   PWDATA,
    output logic [DATA_SIZE/8-1:0] PSTRB,
    input  logic                   PREADY,
    input  logic [DATA_SIZE-1:0]   PRDATA,
    input  logic                   PSLVERR
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t                 state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic                   accept, timeout_hit, done;
    logic [ADDR_SIZE-1:0]   paddr_d;
    logic                   pprot_d, psel_d, penable_d, pwrite_d;
    logic [DATA_SIZE-1:0]   pwdata_d, rsp_rdata_d;
    logic [DATA_SIZE/8-1:0] pstrb_d;
    logic                   rsp_valid_d, rsp_err_d, rsp_timeout_d;

    assign cmd_ready   = state == IDLE;
    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = TIMEOUT_CYCLES != 0 && !PREADY && cnt == CNT_LAST;
    assign done        = state == ACCESS && (PREADY || timeout_hit);
    // the counter only runs while the slave stalls an access; any exit from ACCESS clears it
    assign cnt_d       = TIMEOUT_CYCLES != 0 && state == ACCESS && !PREADY && !timeout_hit ? cnt + CW'(1) : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            PADDR       <= '0;
            PPROT       <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            PADDR       <= paddr_d;
            PPROT       <= pprot_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PWDATA      <= pwdata_d;
            PSTRB       <= pstrb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d = state == IDLE   ? (accept ? SETUP : IDLE) :
                  state == SETUP  ? ACCESS :
                  state == ACCESS ? (done ? RESP : ACCESS) :
                                    (rsp_ready ? IDLE : RESP);
    end

    always_comb begin
        paddr_d       = PADDR;
        pprot_d       = PPROT;
        pwrite_d      = PWRITE;
        pwdata_d      = PWDATA;
        pstrb_d       = PSTRB;
        psel_d        = PSEL;
        penable_d     = PENABLE;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        if (accept) begin
            paddr_d   = cmd_addr;
            pprot_d   = cmd_prot;
            pwrite_d  = cmd_write;
            pwdata_d  = cmd_write ? cmd_wdata : '0;
            pstrb_d   = cmd_write ? cmd_strb : '0;
            psel_d    = 1'b1;
            penable_d = 1'b0;
        end
        if (state == SETUP)
            penable_d = 1'b1;
        // a ready slave beats an expiring timeout on the same edge
        if (done) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = PREADY && !PWRITE ? PRDATA : '0;
            rsp_err_d     = PREADY ? PSLVERR : 1'b1;
            rsp_timeout_d = !PREADY;
        end
        if (state == RESP && rsp_ready)
            rsp_valid_d = 1'b0;
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven APB bridge bench with a response scoreboard and reset corner cases.
module tb_apb_master_bridge;
    localparam int TO = 8;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        prot;
        int          wait_n;
        logic [31:0] prdata;
        logic        slverr;
        logic        noise;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_pen;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    logic        PCLK = 1'b0, PRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_prot = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA = '0;
    logic        PPROT, PSEL, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
    logic [3:0]  PSTRB;
    int          n_chk = 0, n_fail = 0;
    rsp_t        sb[$];
    vec_t        vecs[9];

    apb_master_bridge #(.ADDR_SIZE(32), .DATA_SIZE(32), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        cmd_prot  = v.prot;
    endtask

    task automatic run(input vec_t v, input bit ovl, input vec_t nx);
        int g, k, pen;
        logic [31:0] wd;
        logic [3:0] sd;
        rsp_t got, exp;
        wd = v.wr ? v.wdata : 32'h0;
        sd = v.wr ? v.strb : 4'h0;
        drive_cmd(v);
        g = 0;
        while (!cmd_ready && g < 50) begin
            step();
            g++;
        end
        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        step();
        cmd_valid = 1'b0;
        sb.push_back('{v.exp_rdata, v.exp_err, v.exp_to});
        chk("setup_psel", 64'(PSEL), 64'(1));
        chk("setup_penable", 64'(PENABLE), 64'(0));
        chk("setup_paddr", 64'(PADDR), 64'(v.addr));
        chk("setup_pwrite", 64'(PWRITE), 64'(v.wr));
        chk("setup_pprot", 64'(PPROT), 64'(v.prot));
        chk("setup_pwdata", 64'(PWDATA), 64'(wd));
        chk("setup_pstrb", 64'(PSTRB), 64'(sd));
        chk("setup_cmd_ready", 64'(cmd_ready), 64'(0));
        step();
        k = 1;
        pen = 0;
        while (PENABLE && k < 300) begin
            pen++;
            chk("access_psel", 64'(PSEL), 64'(1));
            chk("access_pwdata", 64'(PWDATA), 64'(wd));
            chk("access_pstrb", 64'(PSTRB), 64'(sd));
            chk("access_paddr", 64'(PADDR), 64'(v.addr));
            PREADY  = k == v.wait_n + 1;
            PSLVERR = PREADY ? v.slverr : v.noise;
            PRDATA  = PREADY ? v.prdata : $urandom;
            step();
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            k++;
        end
        chk("penable_cycles", 64'(pen), 64'(v.exp_pen));
        chk("rsp_valid_up", 64'(rsp_valid), 64'(1));
        chk("done_psel", 64'(PSEL), 64'(0));
        got = '{rsp_rdata, rsp_err, rsp_timeout};
        for (int s = 0; s < v.stall; s++) begin
            if (ovl)
                drive_cmd(nx);
            step();
            chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(got.rdata));
            chk("hold_rsp_flags", 64'({rsp_err, rsp_timeout}), 64'({got.err, got.to}));
            chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            exp = sb.pop_front();
            chk("rsp_rdata", 64'(got.rdata), 64'(exp.rdata));
            chk("rsp_err", 64'(got.err), 64'(exp.err));
            chk("rsp_timeout", 64'(got.to), 64'(exp.to));
        end
        chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
        chk("cmd_ready_after", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        vec_t r;
        int seen;
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h20, 32'h12345678, 4'hF, 1'b0, 2, 32'hCAFEF00D, 1'b0, 1'b0, 0, 32'hCAFEF00D, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b1, 32'h30, 32'h0BADF00D, 4'h3, 1'b0, 3, 32'hFFFFFFFF, 1'b1, 1'b1, 0, 32'h0, 1'b1, 1'b0, 4};
        vecs[3] = '{1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 3, 32'h0000BEEF, 1'b0, 1'b1, 0, 32'h0000BEEF, 1'b0, 1'b0, 4};
        vecs[4] = '{1'b0, 32'h50, 32'h0, 4'h0, 1'b0, 100, 32'h99999999, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 8};
        vecs[5] = '{1'b0, 32'h60, 32'h0, 4'h0, 1'b0, 7, 32'h11223344, 1'b0, 1'b0, 0, 32'h11223344, 1'b0, 1'b0, 8};
        vecs[6] = '{1'b0, 32'h70, 32'hFFFF0000, 4'hF, 1'b1, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 5, 32'hA5A5A5A5, 1'b0, 1'b0, 1};
        vecs[7] = '{1'b1, 32'h80, 32'h55AA55AA, 4'hC, 1'b1, 1, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 2};
        vecs[8] = '{1'b1, 32'h90, 32'h01020304, 4'hF, 1'b0, 100, 32'h0, 1'b0, 1'b1, 2, 32'h0, 1'b1, 1'b1, 8};
        step();
        step();
        chk("reset_psel", 64'(PSEL), 64'(0));
        chk("reset_penable", 64'(PENABLE), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_apb_bus", 64'({PADDR, PWRITE, PPROT, PSTRB}), 64'(0));
        chk("reset_pwdata", 64'(PWDATA), 64'(0));
        chk("reset_rsp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(0));
        PRESET = 1'b0;
        step();
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        for (int i = 0; i < 9; i++)
            run(vecs[i], vecs[i].stall > 0 && i < 8, vecs[i < 8 ? i + 1 : i]);
        // reset pulsed during the second ACCESS cycle of a read
        r = '{1'b0, 32'hA0, 32'h0, 4'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1};
        drive_cmd(r);
        step();
        cmd_valid = 1'b0;
        step();
        chk("rst_mid_access1", 64'(PENABLE), 64'(1));
        step();
        chk("rst_mid_access2", 64'(PENABLE), 64'(1));
        PRESET = 1'b1;
        step();
        chk("rst_mid_psel", 64'(PSEL), 64'(0));
        chk("rst_mid_penable", 64'(PENABLE), 64'(0));
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        PRESET = 1'b0;
        step();
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            PREADY = 1'b1;
            PRDATA = 32'h77777777;
            step();
            if (rsp_valid || PSEL)
                seen++;
        end
        PREADY = 1'b0;
        chk("rst_mid_no_activity", 64'(seen), 64'(0));
        run(vecs[1], 1'b0, vecs[1]);
        run(vecs[0], 1'b0, vecs[0]);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of the APB memory slave. Converts a simple valid/ready command interface from the system side into APB4 transfers (SETUP -> ACCESS) on the PSEL/PENABLE bus.
- Returns one response per command: read data, slave error, or a bridge-generated timeout.
- Only one transfer is in flight at a time. Each accepted command produces exactly one response.

Parameters:
- ADDR_SIZE, 32, APB address width.
- DATA_SIZE, 32, APB data width (multiple of 8).
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles allowed without PREADY; 0 disables the timeout.

Ports:
- PCLK  in  1  sole clock, rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts the command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_SIZE  target address, passed through unmodified.
- cmd_wdata  in  DATA_SIZE  write data.
- cmd_strb  in  DATA_SIZE/8  write byte strobes.
- cmd_prot  in  1  protection attribute.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_SIZE
- PPROT  out  1
- PSEL  out  1
- PENABLE  out  1
- PWRITE  out  1
- PWDATA  out  DATA_SIZE
- PSTRB  out  DATA_SIZE/8
- PREADY  in  1
- PRDATA  in  DATA_SIZE
- PSLVERR  in  1

Behaviour:
- Output registers: all APB outputs and all rsp_* outputs are registered. cmd_ready = (state == IDLE), decoded directly from the state register.
- Reset (PRESET high at a rising edge): state = IDLE, timeout counter = 0, all outputs = 0, so cmd_ready = 1 the cycle after PRESET deasserts.
- Reset mid-transfer: the transfer is abandoned without a response, and PSEL/PENABLE drop at that edge.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cmd_valid & cmd_ready, capture the command.
  - Next state SETUP: PSEL = 1, PENABLE = 0, PADDR/PPROT/PWRITE driven from the captured command.
  - For writes, PWDATA/PSTRB = captured values. For reads, PWDATA = 0 and PSTRB = 0.
- SETUP: exactly one cycle. Next state ACCESS with PENABLE = 1 and all other APB outputs unchanged.
- ACCESS:
  - PADDR, PWRITE, PWDATA, PSTRB, PPROT and PSEL are held stable for the whole state.
  - The timeout counter is 0 on entry and increments once per ACCESS cycle in which PREADY is sampled low.
- ACCESS, completion on PREADY = 1 at an edge:
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - rsp_err = PSLVERR, rsp_timeout = 0.
  - PSEL = PENABLE = 0; next state RESP with rsp_valid = 1.
- ACCESS, timeout: occurs when TIMEOUT_CYCLES != 0, PREADY is low, and the counter == TIMEOUT_CYCLES-1 at an edge.
  - PSEL = PENABLE = 0.
  - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; next state RESP.
  - PENABLE is therefore high for exactly TIMEOUT_CYCLES cycles.
- Simultaneous PREADY and timeout expiry: PREADY wins and the transfer completes normally.
- PSLVERR and PRDATA are ignored whenever PREADY is low.
- RESP:
  - rsp_valid and the rsp_* values are held stable until rsp_valid & rsp_ready at an edge.
  - Then rsp_valid = 0 and next state IDLE. cmd_ready = 0 throughout RESP.
- Throughput: minimum cycles from command accept to rsp_valid = 3 (SETUP, ACCESS with PREADY, then RESP visible). At least one IDLE cycle separates consecutive transfers.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It never wraps because it resets on every ACCESS exit.
- X handling: state transitions are decided on the sampled 0/1 value of PREADY only.

Test Plan:
- Write with zero wait states:
  - Stimulus: cmd addr 0x10, wdata 0xDEADBEEF, strb 0xF; slave PREADY = 1 on the first ACCESS cycle.
  - Response: PSEL high 2 cycles, PENABLE high 1 cycle, PWDATA = 0xDEADBEEF stable throughout; rsp_valid with rsp_err = 0, rsp_rdata = 0.
- Read with wait states:
  - Stimulus: addr 0x20; PREADY high on the 3rd ACCESS cycle with PRDATA = 0xCAFEF00D.
  - Response: PENABLE high 3 cycles, PSTRB = 0, rsp_rdata = 0xCAFEF00D, rsp_err = 0.
- Slave error:
  - Stimulus: write with PREADY = 1 and PSLVERR = 1 in the same cycle.
  - Response: rsp_err = 1, rsp_timeout = 0. A PSLVERR pulse while PREADY = 0 is ignored.
- Timeout, with TIMEOUT_CYCLES = 8:
  - Stimulus: PREADY never asserted.
  - Response: PENABLE high exactly 8 cycles, then rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Repeat with PREADY on the 8th ACCESS cycle: normal completion, rsp_timeout = 0.
- Response backpressure:
  - Stimulus: rsp_ready held low 5 cycles after rsp_valid, with cmd_valid held high for a second command.
  - Response: rsp_valid and rsp_* stay stable and cmd_ready stays 0. The second command is accepted the cycle after the response handshake (cmd_ready = 1 in IDLE).
- Reset mid-transfer:
  - Stimulus: PRESET pulsed during the 2nd ACCESS cycle of a read.
  - Response: PSEL = PENABLE = 0 and rsp_valid = 0 from that edge, no response ever issued, cmd_ready = 1 after release, and the next command completes normally.
